dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the single-port data block RAM (14-bit word address, 32-bit data, synchronous read with 1-cycle latency). It shares the RAM between the CPU load/store path (port C) and the UART program/data loader (port L). Each access runs a fixed IDLE→ISSUE→RESP sequence. When both ports request at once, the arbiter grants them round-robin.

## Interface
Parameters:
- ADDR_W, 14, RAM word-address width; request address bits above ADDR_W-1 are ignored
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- c_req  in  1  CPU request; held with c_we/c_addr/c_wdata stable until c_ack
- c_we  in  1  1 = write (sw), 0 = read (lw)
- c_addr  in  32  CPU word address; bits [ADDR_W-1:0] used
- c_wdata  in  DATA_W  CPU write data
- c_rdata  out  DATA_W  CPU read data; valid during c_ack, then held
- c_ack  out  1  one-cycle completion pulse to CPU
- l_req, l_we, l_addr(32), l_wdata(DATA_W)  in  loader request bundle; same rules as port C
- l_rdata  out  DATA_W  loader read data; same rules as c_rdata
- l_ack  out  1  one-cycle completion pulse to loader
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, valid one cycle after the address is presented
- busy  out  1  high in ISSUE and RESP
- owner  out  1  current or last grant: 0 = C, 1 = L

## Operation
- The FSM has three states: IDLE, ISSUE, RESP.
- **IDLE**
  - If neither port requests, stay in IDLE.
  - If exactly one port requests, grant it.
  - If both request, grant the port selected by the priority pointer `prio` (0 = C, 1 = L).
  - On a grant, latch owner, we, addr[ADDR_W-1:0] and wdata into internal registers, then go to ISSUE.
- **ISSUE**
  - ram_addr and ram_din come from the latched registers.
  - ram_we = latched we AND rst_n.
  - Always go to RESP next.
- **RESP**
  - ram_addr stays on the latched address; ram_we = 0.
  - Assert the owner's ack (c_ack or l_ack).
  - On a read, the owner's rdata output is driven combinationally from ram_dout in this cycle. The owner's rdata register captures ram_dout at the end of RESP.
  - On a write, the owner's rdata register is unchanged.
  - Set prio to the port that was not served, then go to IDLE.
- Outside RESP, c_rdata and l_rdata show their registers.
- The non-owner's ack and rdata are never affected by the other port's transaction.
- Requests are level-sensitive. A port must drop or change its request in the cycle after it sees ack; the next request may be a new one. A req still high in IDLE is treated as a new transaction.
- A request that arrives while busy waits; it is sampled in the next IDLE cycle.
- There is no aborting: once granted, a transaction always completes unless reset occurs.

## Timing
- Request sampled in IDLE in cycle T:
  - ISSUE in T+1; a write happens at the edge ending T+1.
  - RESP in T+2, with ack high for exactly one cycle.
  - IDLE in T+3.
- Minimum spacing is 3 cycles per access.
- Under continuous contention from both ports, grants alternate C, L, C, L…
- Worst-case wait for a requester is one foreign access (3 cycles) plus its own access.
- Reset values (rst_n sampled low):
  - state = IDLE, prio = 0 (C first), owner = 0.
  - Latched we/addr/wdata = 0; c_rdata and l_rdata registers = 0.
  - c_ack = l_ack = 0, busy = 0, ram_we = 0, ram_addr = 0, ram_din = 0.
- Reset in the middle of a transaction:
  - ram_we is gated by rst_n, so no RAM write occurs in any cycle where rst_n = 0.
  - The transaction is dropped without an ack, and the FSM restarts in IDLE.
- Simultaneous assertion of c_req and l_req in IDLE is decided by prio only. Request order in earlier cycles has no effect.

## Test plan
- Single CPU write, then read:
  - Stimulus: c_req, c_we=1, c_addr=0x0000_0010, c_wdata=0xDEAD_BEEF; then a read of the same address.
  - Required: ram_we high for exactly one cycle at T+1 with ram_addr=0x0010; c_ack at T+2 each time; c_rdata=0xDEAD_BEEF during the second ack and held afterwards.
- Upper address bits ignored:
  - Stimulus: l write to l_addr=0xFFFF_C005 with data 0x1234_5678; then a c read of 0x0000_0005.
  - Required: ram_addr=0x0005 for both; c_rdata=0x1234_5678.
- Contention from reset:
  - Stimulus: c_req and l_req both held high, each dropped and re-raised per protocol after its ack.
  - Required: acks in order C, L, C, L at cycles T+2, T+5, T+8, T+11; l_rdata unchanged during C transactions.
- Back-to-back from one port:
  - Stimulus: c_req held high for 4 reads of addresses 0, 1, 2, 3.
  - Required: c_ack every 3 cycles; each c_rdata equals the RAM model word at that address.
- Reset during ISSUE of a write:
  - Stimulus: rst_n=0 in cycle T+1 of a write of 0xAAAA_AAAA to address 0x20.
  - Required: ram_we stays 0; no ack; RAM[0x20] unchanged; the cycle after reset shows state IDLE, busy=0, and both rdata outputs 0.
- Late request while busy:
  - Stimulus: l_req raised in cycle T+1 of a CPU access.
  - Required: L granted in IDLE at T+3; l_ack at T+5; busy high over T+1 to T+2 and T+4 to T+5.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and IDLE/ISSUE/RESP sequencer that shares
// one synchronous-read data RAM between the CPU port (C) and the loader port (L).
module dmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state;
  state_t              next_state;
  logic                prio;
  logic                grant_valid;
  logic                grant_port;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   c_rdata_q;
  logic [DATA_W-1:0]   l_rdata_q;

  // Upper request address bits are deliberately ignored by the RAM mapping.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c_addr[31:ADDR_W], l_addr[31:ADDR_W]};

  // State register; reset always returns to IDLE, dropping any transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and grant decision: a lone requester wins, a tie goes to prio.
  always_comb begin
    next_state  = state;
    grant_valid = 1'b0;
    grant_port  = prio;
    case (state)
      IDLE: begin
        if (c_req || l_req) begin
          grant_valid = 1'b1;
          grant_port  = (c_req && l_req) ? prio : l_req;
          next_state  = ISSUE;
        end
      end
      ISSUE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the granted request, capture read data and rotate priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio      <= 1'b0;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      if (grant_valid) begin
        owner     <= grant_port;
        lat_we    <= grant_port ? l_we : c_we;
        lat_addr  <= grant_port ? l_addr[ADDR_W-1:0] : c_addr[ADDR_W-1:0];
        lat_wdata <= grant_port ? l_wdata : c_wdata;
      end
      if (state == RESP) begin
        prio <= ~owner;
        if (!lat_we) begin
          if (owner) l_rdata_q <= ram_dout;
          else       c_rdata_q <= ram_dout;
        end
      end
    end
  end

  // RAM drive, acks and read-data bypass; the write strobe is gated by reset.
  always_comb begin
    ram_addr = lat_addr;
    ram_din  = lat_wdata;
    ram_we   = (state == ISSUE) && lat_we && rst_n;
    busy     = (state != IDLE);
    c_ack    = (state == RESP) && !owner;
    l_ack    = (state == RESP) && owner;
    c_rdata  = c_rdata_q;
    l_rdata  = l_rdata_q;
    if (state == RESP && !lat_we) begin
      if (owner) l_rdata = ram_dout;
      else       c_rdata = ram_dout;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a scoreboard queue of expected acks;
// a negedge monitor pops and checks each ack while the main thread drives.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic [31:0] c_rdata, l_rdata, ram_din, ram_dout;
  logic        c_ack, l_ack, ram_we, busy, owner;
  logic [13:0] ram_addr;

  typedef struct {
    bit          port;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem [0:16383];

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_ack(l_ack),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .owner(owner)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (c_ack || l_ack) begin
      if (c_ack && l_ack) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL dual_ack: both acks high at cycle %0d, expected one", cyc);
      end else if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_ack: c_ack=%b l_ack=%b at cycle %0d, expected none",
                 c_ack, l_ack, cyc);
      end else begin
        e = sb.pop_front();
        check_output("ack_port", {31'd0, l_ack}, {31'd0, e.port});
        check_output("ack_cycle", cyc, e.cyc);
        if (e.rd) check_output("ack_rdata", e.port ? l_rdata : c_rdata, e.data);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(bit port, bit we, logic [31:0] addr, logic [31:0] wdata);
    if (port) begin
      l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
    end
  endtask

  task automatic release_req(bit port);
    if (port) l_req = 1'b0;
    else      c_req = 1'b0;
  endtask

  task automatic expect_ack(bit port, bit rd, logic [31:0] data, int at);
    exp_t e;
    e.port = port; e.rd = rd; e.data = data; e.cyc = at;
    sb.push_back(e);
  endtask

  // One isolated access from IDLE: checks the RAM strobe in ISSUE and RESP.
  task automatic single_access(bit port, bit we, logic [31:0] addr, logic [31:0] wdata,
                               logic [31:0] rdata, logic [13:0] exp_addr);
    apply_stimulus(port, we, addr, wdata);
    expect_ack(port, !we, rdata, cyc + 2);
    step(1);
    check_output("issue_ram_we", {31'd0, ram_we}, {31'd0, we});
    check_output("issue_ram_addr", {18'd0, ram_addr}, {18'd0, exp_addr});
    if (we) check_output("issue_ram_din", ram_din, wdata);
    step(1);
    check_output("resp_ram_we", {31'd0, ram_we}, 32'd0);
    release_req(port);
    step(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int t;
    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0000 + i;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    rst_n = 1'b0;
    step(2);

    // Reset values
    check_output("rst_outs", {25'd0, c_ack, l_ack, busy, ram_we, owner, 2'b00},
                 32'd0);
    check_output("rst_ram_addr", {18'd0, ram_addr}, 32'd0);
    check_output("rst_ram_din", ram_din, 32'd0);
    check_output("rst_c_rdata", c_rdata, 32'd0);
    check_output("rst_l_rdata", l_rdata, 32'd0);
    rst_n = 1'b1;
    step(1);

    // CPU write then read of word 0x10
    single_access(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 14'h0010);
    single_access(0, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 14'h0010);
    check_output("c_rdata_held", c_rdata, 32'hDEAD_BEEF);
    step(2);
    check_output("c_rdata_held2", c_rdata, 32'hDEAD_BEEF);

    // Upper address bits ignored
    single_access(1, 1, 32'hFFFF_C005, 32'h1234_5678, 32'h0, 14'h0005);
    single_access(0, 0, 32'h0000_0005, 32'h0, 32'h1234_5678, 14'h0005);

    // Back-to-back reads from C with req held high
    t = cyc;
    apply_stimulus(0, 0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      expect_ack(0, 1, 32'h1000_0000 + i, t + 2 + 3 * i);
      step(2);
      c_addr = i + 1;
      step(1);
    end
    release_req(0);
    step(2);

    // Contention from reset: C, L, C, L
    do_reset();
    t = cyc;
    apply_stimulus(0, 0, 32'd1, 32'd0);
    apply_stimulus(1, 0, 32'd2, 32'd0);
    expect_ack(0, 1, 32'h1000_0001, t + 2);
    expect_ack(1, 1, 32'h1000_0002, t + 5);
    expect_ack(0, 1, 32'h1000_0001, t + 8);
    expect_ack(1, 1, 32'h1000_0002, t + 11);
    step(2);
    check_output("cont_l_rdata_1", l_rdata, 32'd0);
    step(3);
    check_output("cont_c_rdata_1", c_rdata, 32'h1000_0001);
    step(3);
    check_output("cont_l_rdata_2", l_rdata, 32'h1000_0002);
    step(3);
    check_output("cont_c_rdata_2", c_rdata, 32'h1000_0001);
    release_req(0);
    release_req(1);
    step(2);

    // Late L request while a C access is in flight
    t = cyc;
    apply_stimulus(0, 0, 32'd3, 32'd0);
    expect_ack(0, 1, 32'h1000_0003, t + 2);
    check_output("late_busy_t0", {31'd0, busy}, 32'd0);
    step(1);
    check_output("late_busy_t1", {31'd0, busy}, 32'd1);
    apply_stimulus(1, 0, 32'd2, 32'd0);
    expect_ack(1, 1, 32'h1000_0002, t + 5);
    step(1);
    check_output("late_busy_t2", {31'd0, busy}, 32'd1);
    release_req(0);
    step(1);
    check_output("late_busy_t3", {31'd0, busy}, 32'd0);
    step(1);
    check_output("late_busy_t4", {31'd0, busy}, 32'd1);
    step(1);
    check_output("late_busy_t5", {31'd0, busy}, 32'd1);
    release_req(1);
    step(2);

    // Reset during ISSUE of a write to 0x20
    apply_stimulus(0, 1, 32'h0000_0020, 32'hAAAA_AAAA);
    step(1);
    rst_n = 1'b0;
    release_req(0);
    #1;
    check_output("rst_issue_ram_we", {31'd0, ram_we}, 32'd0);
    step(1);
    check_output("post_rst_busy", {31'd0, busy}, 32'd0);
    check_output("post_rst_c_rdata", c_rdata, 32'd0);
    check_output("post_rst_l_rdata", l_rdata, 32'd0);
    rst_n = 1'b1;
    step(1);
    single_access(0, 0, 32'h0000_0020, 32'h0, 32'h0000_0000, 14'h0020);

    step(3);
    check_output("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
